// File: rtl/hdmi_i2c_init.sv
// hdmi_i2c_init
//   Power-up and hot-plug configuration of an HDMI transmitter over I2C.
//   After STARTUP_CYCLES the block writes a fixed 12-entry {reg,data} table to
//   DEV_ADDR, one register per I2C transaction. A NACK retries the entry up to
//   RETRY_MAX attempts, then aborts. A falling edge on HDMI_TX_INT starts a new
//   run; an edge seen during a run queues exactly one follow-up run.
//
// Ports
//   iCLK        : sole clock, rising edge
//   iRST_N      : asynchronous active-low reset; releases both bus lines at once
//   I2C_SCLK    : open-drain I2C clock (drives 0 or Z), read back for stretching
//   I2C_SDAT    : open-drain I2C data (drives 0 or Z), read back for ACK
//   HDMI_TX_INT : transmitter interrupt / hot-plug, active-low, asynchronous
//   cfg_busy    : configuration run in progress
//   cfg_done    : last run wrote every entry with all ACKs
//   cfg_error   : last run aborted after RETRY_MAX NACKs on one entry
module hdmi_i2c_init #(
    parameter int unsigned CLK_DIV        = 125,
    parameter int unsigned STARTUP_CYCLES = 1000000,
    parameter logic [7:0]  DEV_ADDR       = 8'h72,
    parameter int unsigned RETRY_MAX      = 3
) (
    input  logic iCLK,
    input  logic iRST_N,
    inout  wire  I2C_SCLK,
    inout  wire  I2C_SDAT,
    input  logic HDMI_TX_INT,
    output logic cfg_busy,
    output logic cfg_done,
    output logic cfg_error
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PWR_W = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
    localparam int unsigned ATT_W = $clog2(RETRY_MAX + 1);
    localparam logic [3:0]  LAST_ENTRY = 4'd11;

    typedef enum logic [3:0] {
        WAIT_PWR, IDLE, START, SHIFT, ACK, STOP, GAP, DONE, FAIL
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       phase;
    logic [PWR_W-1:0] pwr_cnt;
    logic [3:0]       index;
    logic [ATT_W-1:0] attempt;
    logic [ATT_W-1:0] attempt_nxt;
    logic [1:0]       byte_sel;
    logic [2:0]       bit_cnt;
    logic             nack;
    logic             pending;
    logic             scl_rel;
    logic             sda_rel;
    logic [1:0]       scl_sync;
    logic [1:0]       sda_sync;
    logic [1:0]       int_sync;
    logic             int_prev;
    logic             tick;
    logic             stretched;
    logic             step;
    logic             int_fall;
    logic             run_req;
    logic [15:0]      rom_word;
    logic [7:0]       cur_byte;

    // Open-drain drivers: only ever pull low or release.
    assign I2C_SCLK = scl_rel ? 1'bz : 1'b0;
    assign I2C_SDAT = sda_rel ? 1'bz : 1'b0;

    always_comb begin
        rom_word = 16'h0000;
        case (index)
            4'd0:    rom_word = 16'h4110;
            4'd1:    rom_word = 16'h9803;
            4'd2:    rom_word = 16'h9AE0;
            4'd3:    rom_word = 16'h9C30;
            4'd4:    rom_word = 16'h9D61;
            4'd5:    rom_word = 16'hA2A4;
            4'd6:    rom_word = 16'hA3A4;
            4'd7:    rom_word = 16'hE0D0;
            4'd8:    rom_word = 16'hF900;
            4'd9:    rom_word = 16'h1500;
            4'd10:   rom_word = 16'h1630;
            4'd11:   rom_word = 16'hAF14;
            default: rom_word = 16'h0000;
        endcase
    end

    always_comb begin
        cur_byte = DEV_ADDR;
        case (byte_sel)
            2'd0:    cur_byte = DEV_ADDR;
            2'd1:    cur_byte = rom_word[15:8];
            default: cur_byte = rom_word[7:0];
        endcase
    end

    always_comb begin
        tick        = (div_cnt == DIV_W'(CLK_DIV - 1));
        // A released SCL that still reads low is a slave stretching the clock;
        // the bit phase is frozen until the line actually rises.
        stretched   = scl_rel && !scl_sync[1];
        step        = tick && !stretched;
        int_fall    = int_prev && !int_sync[1];
        attempt_nxt = attempt + ATT_W'(1);
        run_req     = ((state == WAIT_PWR) && (pwr_cnt == PWR_W'(STARTUP_CYCLES))) ||
                      ((state == IDLE) && (int_fall || pending));
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= WAIT_PWR;
            div_cnt   <= '0;
            phase     <= '0;
            pwr_cnt   <= '0;
            index     <= '0;
            attempt   <= '0;
            byte_sel  <= '0;
            bit_cnt   <= '0;
            nack      <= 1'b0;
            pending   <= 1'b0;
            scl_rel   <= 1'b1;
            sda_rel   <= 1'b1;
            scl_sync  <= '1;
            sda_sync  <= '1;
            int_sync  <= '1;
            int_prev  <= 1'b1;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[0], I2C_SCLK};
            sda_sync <= {sda_sync[0], I2C_SDAT};
            int_sync <= {int_sync[0], HDMI_TX_INT};
            int_prev <= int_sync[1];
            div_cnt  <= tick ? '0 : div_cnt + DIV_W'(1);

            // Hot-plug during a run (or in its final DONE/FAIL cycle) queues one more run.
            if (int_fall && (state != IDLE) && (state != WAIT_PWR)) begin
                pending <= 1'b1;
            end

            if (run_req) begin
                state     <= START;
                phase     <= '0;
                index     <= '0;
                attempt   <= '0;
                pending   <= 1'b0;
                cfg_busy  <= 1'b1;
                cfg_done  <= 1'b0;
                cfg_error <= 1'b0;
            end else begin
                case (state)
                    WAIT_PWR: pwr_cnt <= pwr_cnt + PWR_W'(1);
                    IDLE: ;
                    DONE: begin
                        cfg_done <= 1'b1;
                        cfg_busy <= 1'b0;
                        state    <= IDLE;
                    end
                    FAIL: begin
                        cfg_error <= 1'b1;
                        cfg_done  <= 1'b0;
                        cfg_busy  <= 1'b0;
                        scl_rel   <= 1'b1;
                        sda_rel   <= 1'b1;
                        state     <= IDLE;
                    end
                    default: begin
                        if (step) begin
                            phase <= phase + 2'd1;
                            case (state)
                                START: begin
                                    case (phase)
                                        2'd0: begin
                                            scl_rel <= 1'b1;
                                            sda_rel <= 1'b1;
                                        end
                                        2'd1: sda_rel <= 1'b0;
                                        2'd3: begin
                                            scl_rel  <= 1'b0;
                                            byte_sel <= 2'd0;
                                            bit_cnt  <= 3'd7;
                                            nack     <= 1'b0;
                                            state    <= SHIFT;
                                        end
                                        default: ;
                                    endcase
                                end
                                SHIFT: begin
                                    case (phase)
                                        2'd0: sda_rel <= cur_byte[bit_cnt];
                                        2'd1: scl_rel <= 1'b1;
                                        2'd3: begin
                                            scl_rel <= 1'b0;
                                            if (bit_cnt == 3'd0) begin
                                                state <= ACK;
                                            end else begin
                                                bit_cnt <= bit_cnt - 3'd1;
                                            end
                                        end
                                        default: ;
                                    endcase
                                end
                                ACK: begin
                                    case (phase)
                                        2'd0: sda_rel <= 1'b1;
                                        2'd1: scl_rel <= 1'b1;
                                        2'd2: nack    <= sda_sync[1];
                                        default: begin
                                            scl_rel <= 1'b0;
                                            // A NACK skips the remaining bytes of this entry.
                                            if (nack || (byte_sel == 2'd2)) begin
                                                state <= STOP;
                                            end else begin
                                                byte_sel <= byte_sel + 2'd1;
                                                bit_cnt  <= 3'd7;
                                                state    <= SHIFT;
                                            end
                                        end
                                    endcase
                                end
                                STOP: begin
                                    case (phase)
                                        2'd0: sda_rel <= 1'b0;
                                        2'd1: scl_rel <= 1'b1;
                                        2'd3: begin
                                            sda_rel <= 1'b1;
                                            if (nack) begin
                                                if (attempt_nxt < ATT_W'(RETRY_MAX)) begin
                                                    attempt <= attempt_nxt;
                                                    state   <= GAP;
                                                end else begin
                                                    state <= FAIL;
                                                end
                                            end else if (index == LAST_ENTRY) begin
                                                state <= DONE;
                                            end else begin
                                                index   <= index + 4'd1;
                                                attempt <= '0;
                                                state   <= GAP;
                                            end
                                        end
                                        default: ;
                                    endcase
                                end
                                GAP: begin
                                    if (phase == 2'd3) begin
                                        state <= START;
                                    end
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdmi_i2c_init.sv
// Bench for hdmi_i2c_init with a behavioural I2C slave on pulled-up lines.
// The slave logs every received byte and START, answers ACK/NACK according
// to per-scenario settings and can stretch SCL once.
module tb_hdmi_i2c_init;

    localparam int CLK_DIV = 4;
    localparam int STARTUP = 16;
    localparam int TMO     = 20000;

    logic iCLK = 1'b0;
    logic rst_n = 1'b0;
    logic hdmi_int = 1'b1;
    logic cfg_busy, cfg_done, cfg_error;

    wire scl_w;
    wire sda_w;
    pullup (scl_w);
    pullup (sda_w);

    logic slv_scl_low = 1'b0;
    logic slv_sda_low = 1'b0;
    assign scl_w = slv_scl_low ? 1'b0 : 1'bz;
    assign sda_w = slv_sda_low ? 1'b0 : 1'bz;

    hdmi_i2c_init #(
        .CLK_DIV        (CLK_DIV),
        .STARTUP_CYCLES (STARTUP),
        .DEV_ADDR       (8'h72),
        .RETRY_MAX      (3)
    ) u_dut (
        .iCLK        (iCLK),
        .iRST_N      (rst_n),
        .I2C_SCLK    (scl_w),
        .I2C_SDAT    (sda_w),
        .HDMI_TX_INT (hdmi_int),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_error   (cfg_error)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_fail   = 0;

    // slave configuration
    bit         nack_addr_all = 1'b0;
    logic [7:0] nack_reg_val  = 8'h00;
    int         nack_reg_left = 0;
    bit         stretch_arm   = 1'b0;

    // slave observations
    logic [7:0] bytes_q[$];
    logic [7:0] exp_q[$];
    int starts = 0;
    int bitn = 0;
    bit in_ack = 1'b0;
    int stretch_left = 0;
    bit stretch_seen = 1'b0;
    int stretch_sda_chg = 0;
    int post_high = 0;
    bit post_meas = 1'b0;

    logic [15:0] rom_exp [12];

    typedef struct {
        bit         nack_addr;
        logic [7:0] nack_reg;
        int         nack_cnt;
        int         exp_starts;
        bit         exp_done;
        bit         exp_err;
    } vec_t;
    vec_t vecs [3];

    initial begin : slave
        logic ps, pd, s, d;
        logic [7:0] sh;
        int byten;
        ps = 1'b1; pd = 1'b1; sh = 8'h00; byten = 0;
        forever begin
            @(negedge iCLK);
            s = (scl_w !== 1'b0);
            d = (sda_w !== 1'b0);
            if (!rst_n) begin
                slv_scl_low = 1'b0;
                slv_sda_low = 1'b0;
                bitn = 0;
                in_ack = 1'b0;
                stretch_left = 0;
                post_meas = 1'b0;
            end else begin
                if (stretch_left > 0 && stretch_left <= 12 && d != pd) stretch_sda_chg++;
                if (post_meas && s) post_high++;
                if (s && ps && pd && !d) begin
                    starts++;
                    bitn = 0;
                    in_ack = 1'b0;
                    byten = 0;
                    slv_sda_low = 1'b0;
                end else if (s && !ps) begin
                    if (!in_ack && bitn < 8) begin
                        sh = {sh[6:0], d};
                        bitn++;
                        if (bitn == 8) bytes_q.push_back(sh);
                    end
                end else if (!s && ps) begin
                    post_meas = 1'b0;
                    if (in_ack) begin
                        in_ack = 1'b0;
                        slv_sda_low = 1'b0;
                        bitn = 0;
                        byten++;
                    end else if (bitn == 8) begin
                        in_ack = 1'b1;
                        if (byten == 0 && nack_addr_all) begin
                            slv_sda_low = 1'b0;
                        end else if (byten == 1 && sh == nack_reg_val && nack_reg_left > 0) begin
                            nack_reg_left--;
                            slv_sda_low = 1'b0;
                        end else begin
                            slv_sda_low = 1'b1;
                        end
                    end
                    if (stretch_arm && !in_ack && bitn == 3) begin
                        stretch_arm = 1'b0;
                        stretch_left = 20;
                        stretch_seen = 1'b1;
                    end
                end
                if (stretch_left > 0) begin
                    slv_scl_low = 1'b1;
                    stretch_left--;
                end else if (slv_scl_low) begin
                    slv_scl_low = 1'b0;
                    post_meas = 1'b1;
                    post_high = 0;
                end
            end
            ps = s;
            pd = d;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Expected byte stream for a slave with the given NACK behaviour.
    task automatic build_exp(input bit na, input logic [7:0] nr, input int nc);
        int left, att;
        bit ok;
        left = nc;
        exp_q.delete();
        for (int e = 0; e < 12; e++) begin
            att = 0;
            ok = 1'b0;
            while (!ok && att < 3) begin
                exp_q.push_back(8'h72);
                if (na) begin
                    att++;
                end else if (rom_exp[e][15:8] == nr && left > 0) begin
                    exp_q.push_back(rom_exp[e][15:8]);
                    left--;
                    att++;
                end else begin
                    exp_q.push_back(rom_exp[e][15:8]);
                    exp_q.push_back(rom_exp[e][7:0]);
                    ok = 1'b1;
                end
            end
            if (!ok) break;
        end
    endtask

    task automatic do_reset(input bit na, input logic [7:0] nr, input int nc, input bit sarm);
        @(negedge iCLK);
        rst_n = 1'b0;
        #1;
        check("rst_busy", cfg_busy, 0);
        check("rst_done", cfg_done, 0);
        check("rst_error", cfg_error, 0);
        check("rst_scl_released", (scl_w !== 1'b0), 1);
        nack_addr_all = na;
        nack_reg_val = nr;
        nack_reg_left = nc;
        stretch_arm = sarm;
        stretch_seen = 1'b0;
        stretch_sda_chg = 0;
        post_high = 0;
        repeat (3) @(negedge iCLK);
        bytes_q.delete();
        starts = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_end(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(posedge iCLK);
            #1;
            if (cfg_done || cfg_error) begin
                ok = 1'b1;
                break;
            end
        end
        check(nm, ok, 1);
    endtask

    task automatic wait_starts(input int n, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(posedge iCLK);
            #1;
            if (starts >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check(nm, ok, 1);
    endtask

    task automatic compare_bytes(input string nm, input int reps);
        check({nm, "_count"}, bytes_q.size(), exp_q.size() * reps);
        for (int i = 0; i < bytes_q.size() && i < exp_q.size() * reps; i++) begin
            check($sformatf("%s_byte%0d", nm, i), bytes_q[i], exp_q[i % exp_q.size()]);
        end
    endtask

    initial begin
        bit ok;
        rom_exp = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
                    16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'hAF14};
        vecs[0] = '{1'b0, 8'h00, 0, 12, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 8'h9C, 2, 14, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h00, 0, 3,  1'b0, 1'b1};

        for (int v = 0; v < 3; v++) begin
            do_reset(vecs[v].nack_addr, vecs[v].nack_reg, vecs[v].nack_cnt, 1'b0);
            build_exp(vecs[v].nack_addr, vecs[v].nack_reg, vecs[v].nack_cnt);
            repeat (12) @(posedge iCLK);
            #1;
            check($sformatf("v%0d_startup_quiet", v), starts, 0);
            check($sformatf("v%0d_startup_busy", v), cfg_busy, 0);
            wait_starts(1, $sformatf("v%0d_first_start", v));
            check($sformatf("v%0d_run_busy", v), cfg_busy, 1);
            wait_end($sformatf("v%0d_run_end", v));
            check($sformatf("v%0d_done", v), cfg_done, vecs[v].exp_done);
            check($sformatf("v%0d_error", v), cfg_error, vecs[v].exp_err);
            check($sformatf("v%0d_busy_end", v), cfg_busy, 0);
            repeat (600) @(posedge iCLK);
            #1;
            check($sformatf("v%0d_starts", v), starts, vecs[v].exp_starts);
            compare_bytes($sformatf("v%0d", v), 1);
        end

        // Hot-plug after DONE, then another edge mid-run queues exactly one extra run.
        do_reset(1'b0, 8'h00, 0, 1'b0);
        build_exp(1'b0, 8'h00, 0);
        wait_end("int_first_run");
        bytes_q.delete();
        starts = 0;
        @(negedge iCLK);
        hdmi_int = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        check("int_done_clr", cfg_done, 0);
        check("int_busy_set", cfg_busy, 1);
        repeat (7) @(negedge iCLK);
        hdmi_int = 1'b1;
        wait_starts(3, "int_run2_started");
        @(negedge iCLK);
        hdmi_int = 1'b0;
        repeat (10) @(negedge iCLK);
        hdmi_int = 1'b1;
        wait_end("int_run2_end");
        check("int_run2_done", cfg_done, 1);
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge iCLK);
            #1;
            if (!cfg_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("int_extra_run", ok, 1);
        wait_end("int_run3_end");
        check("int_run3_done", cfg_done, 1);
        check("int_run3_error", cfg_error, 0);
        repeat (2000) @(posedge iCLK);
        #1;
        check("int_starts", starts, 24);
        check("int_idle_done", cfg_done, 1);
        compare_bytes("int", 2);

        // Clock stretching on the address byte of entry 0.
        do_reset(1'b0, 8'h00, 0, 1'b1);
        wait_end("str_run_end");
        check("str_done", cfg_done, 1);
        check("str_seen", stretch_seen, 1);
        check("str_sda_stable", stretch_sda_chg, 0);
        check("str_scl_high_after", (post_high >= CLK_DIV), 1);
        repeat (50) @(posedge iCLK);
        compare_bytes("str", 1);

        // Reset in the middle of the register byte of entry 5.
        do_reset(1'b0, 8'h00, 0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(posedge iCLK);
            #1;
            if (bytes_q.size() >= 16 && bitn == 4 && !in_ack) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_reach_entry5", ok, 1);
        check("mid_entry5_addr", bytes_q[15], 8'h72);
        rst_n = 1'b0;
        #1;
        check("mid_scl_released", (scl_w !== 1'b0), 1);
        check("mid_sda_released", (sda_w !== 1'b0), 1);
        check("mid_busy", cfg_busy, 0);
        check("mid_done", cfg_done, 0);
        check("mid_error", cfg_error, 0);
        repeat (3) @(negedge iCLK);
        bytes_q.delete();
        starts = 0;
        rst_n = 1'b1;
        repeat (12) @(posedge iCLK);
        #1;
        check("mid_startup_quiet", starts, 0);
        wait_end("mid_run_end");
        check("mid_run_done", cfg_done, 1);
        repeat (50) @(posedge iCLK);
        compare_bytes("mid", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
